ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Upstream sequencer that turns the 16x4 single-port ram into a FIFO. Accepts words on a
//  valid/ready push port, writes them at wr_ptr, prefetches the oldest word into a 1-entry
//  output register and presents it on a valid/ready pop port. Owns every ram input
//  (ip, address, rd_wr) and consumes ram op. Only one ram access per cycle.
// PARAMETERS
//  DW      4   data width; equals ram ip/op width
//  AW      4   address width; equals ram address width
//  DEPTH   16  ram words used; must equal 2**AW
//  RD_LAT  1   cycles from read issue to valid ram_op. 1 = async read, 2 = registered op.
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  wr_valid     in   1      push request
//  wr_data      in   DW     push word
//  wr_ready     out  1      push accepted when wr_valid & wr_ready at clk edge
//  rd_valid     out  1      rd_data holds oldest word
//  rd_data      out  DW     oldest word (output register)
//  rd_ready     in   1      pop; word consumed when rd_valid & rd_ready at clk edge
//  count        out  AW+1   words in ram not yet fetched (excludes output register)
//  full         out  1      count == DEPTH
//  empty        out  1      count == 0 & !rd_valid
//  ram_ip       out  DW     to ram ip
//  ram_address  out  AW     to ram address
//  ram_rd_wr    out  1      to ram rd_wr: 0 = write, 1 = read
//  ram_op       in   DW     from ram op
// BEHAVIOUR
//  Reset (async): wr_ptr = rd_ptr = 0, count = 0, rd_valid = 0, rd_data = 0, state = IDLE,
//   lat_cnt = 0. While rst = 1, ram_rd_wr = 1 so no spurious write. Ram contents not cleared.
//  FSM: IDLE (port free) / RDWAIT (read in flight for RD_LAT cycles).
//  IDLE -> RDWAIT when count != 0 & !rd_valid. This read has priority over writes.
//   On the issuing edge: count-1, rd_ptr+1. The read address is latched.
//  RDWAIT: ram_rd_wr = 1, ram_address = latched read address, held for RD_LAT cycles total.
//   On the last edge: rd_data <= ram_op, rd_valid <= 1, state -> IDLE.
//  wr_ready = (state == IDLE) & !full & !(count != 0 & !rd_valid). Registered terms only;
//   no path from wr_valid or rd_ready to wr_ready.
//  Write cycle (wr_valid & wr_ready): ram_rd_wr = 0, ram_address = wr_ptr, ram_ip = wr_data.
//   On the edge: wr_ptr+1, count+1.
//  Idle drive (no write, no read): ram_rd_wr = 1, ram_address = rd_ptr, ram_ip = 0.
//  Pop: rd_valid & rd_ready clears rd_valid on the edge. The next prefetch issues the
//   following cycle, so sustained pop rate = 1 word per (RD_LAT+1) cycles.
//  Pointers wrap DEPTH-1 -> 0. count never exceeds DEPTH and never underflows.
//   Push while full: not accepted. Pop while !rd_valid: ignored.
//  Same-cycle write and read issue never occur; the single port is arbitrated by the rules
//   above. Pop plus write in the same cycle is legal.
//  Latency, empty FIFO: write edge T -> read issue T+1 -> rd_valid from T+1+RD_LAT.
//  Capacity: DEPTH words in ram plus 1 in the output register.
//  Reset mid-read: read aborted, fetched word discarded, FIFO empty afterwards.
// STRUCTURE
//  Shared include ram_defs.vh holds:
//   - DW/AW defaults
//   - state encodings IDLE = 1'b0, RDWAIT = 1'b1
//   - RD/WR encodings of rd_wr
//  Sub-module ram_fifo_ptr: AW-bit wrapping counter with inc enable and async rst.
//   Instantiated for wr_ptr and rd_ptr.
//  Top-level wrapper connects ram_fifo_ctrl to ram one-to-one (ram_ip->ip, ...).
// TESTING (bench with real ram, RD_LAT matched to it)
//  Reset: rst 1 mid-run -> rd_valid 0, count 0, empty 1, ram_rd_wr 1 immediately.
//  Single word: push 4'b1011 once -> one cycle with ram_rd_wr=0, address 0, ip 1011;
//   then rd_valid, rd_data=1011 after RD_LAT+1 cycles, count back to 0.
//  Fill: hold rd_ready=0, push 0..F -> 16 writes land in ram (rd_valid word 0 prefetched).
//   Then push 1 more -> full 1, wr_ready 0 while rd_ready=0.
//  Drain: rd_ready=1 -> words pop in order 0..F, one per RD_LAT+1 cycles. empty after last.
//  Wrap: 40 pushes/pops interleaved, random valid/ready -> output equals input order,
//   pointers pass 15->0, no lost or duplicated word.
//  Simultaneous: rd_valid=1, pop and push on the same edge -> both take effect,
//   count unchanged net of pending prefetch, ram_rd_wr never 0 during RDWAIT.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared encodings for the single-port ram FIFO sequencer: FSM states and ram rd_wr values.
package ram_fifo_ctrl_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        RDWAIT = 1'b1
    } state_e;

    localparam logic RAM_WR = 1'b0;
    localparam logic RAM_RD = 1'b1;

endpackage

// File: rtl/ram_fifo_ctrl_ptr.sv
// AW-bit wrapping pointer with increment enable; wraps naturally because DEPTH == 2**AW.
module ram_fifo_ptr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Turns a single-port ram into a FIFO with a 1-entry prefetched output register.
// Prefetch reads take priority over writes; wr_ready depends on registered state only.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] ram_ip,
    output logic [AW-1:0] ram_address,
    output logic          ram_rd_wr,
    input  logic [DW-1:0] ram_op
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e        state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_inc, rd_inc;
    logic          need_rd;
    logic          wr_fire;
    logic          lat_last;

    ram_fifo_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_inc), .ptr(wr_ptr));
    ram_fifo_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_inc), .ptr(rd_ptr));

    assign need_rd  = (count_q != '0) && !rd_valid_q;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0) && !rd_valid_q;
    assign wr_ready = (state_q == IDLE) && !full && !need_rd;
    assign wr_fire  = wr_valid && wr_ready;
    assign lat_last = (lat_cnt_q == LW'(RD_LAT - 1));

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        rd_addr_d  = rd_addr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        wr_inc     = 1'b0;
        rd_inc     = 1'b0;

        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (need_rd) begin
                    state_d   = RDWAIT;
                    lat_cnt_d = '0;
                    rd_addr_d = rd_ptr;
                    rd_inc    = 1'b1;
                    count_d   = count_q - (AW+1)'(1);
                end else if (wr_fire) begin
                    wr_inc  = 1'b1;
                    count_d = count_q + (AW+1)'(1);
                end
            end
            RDWAIT: begin
                if (lat_last) begin
                    rd_data_d  = ram_op;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            rd_addr_q  <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_addr_q  <= rd_addr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Ram port drive; reset forces read so a stray wr_valid cannot corrupt ram
    always_comb begin
        ram_rd_wr   = RAM_RD;
        ram_address = rd_ptr;
        ram_ip      = '0;
        if (!rst) begin
            if (state_q == RDWAIT) begin
                ram_address = rd_addr_q;
            end else if (wr_fire) begin
                ram_rd_wr   = RAM_WR;
                ram_address = wr_ptr;
                ram_ip      = wr_data;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a 16x4 async-read ram attached (RD_LAT = 1).
module tb_ram_fifo_ctrl;

    localparam int DW     = 4;
    localparam int AW     = 4;
    localparam int RD_LAT = 1;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [DW-1:0] ram_ip;
    logic [AW-1:0] ram_address;
    logic          ram_rd_wr;
    logic [DW-1:0] ram_op;

    logic [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty),
        .ram_ip(ram_ip), .ram_address(ram_address), .ram_rd_wr(ram_rd_wr),
        .ram_op(ram_op)
    );

    // 16x4 single-port ram, asynchronous read
    assign ram_op = mem[ram_address];
    always @(posedge clk) if (!ram_rd_wr) mem[ram_address] <= ram_ip;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check_eq("push_timeout", 32'(n), 32'd0);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [DW-1:0] d, output int waited);
        int n;
        n = 0;
        while (!rd_valid && n < 20) begin
            step();
            n++;
        end
        waited = n;
        check_eq(tag, {28'd0, rd_data}, {28'd0, d});
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] nxt;
        logic [DW-1:0] cap;
        int            w;
        int            sent;
        int            got;
        int            cyc;
        logic          acc_w;
        logic          acc_r;

        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 4'hF;
        rd_ready = 1'b0;

        // Reset: ram must not be written even with wr_valid asserted
        #3;
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_rd_wr", 32'(ram_rd_wr), 32'd1);
        step();
        check_eq("rst_rd_wr_edge", 32'(ram_rd_wr), 32'd1);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        wr_valid = 1'b0;
        rst      = 1'b0;
        step();

        // Single word
        wr_valid = 1'b1;
        wr_data  = 4'b1011;
        #1;
        check_eq("sw_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("sw_rd_wr", 32'(ram_rd_wr), 32'd0);
        check_eq("sw_addr", 32'(ram_address), 32'd0);
        check_eq("sw_ip", 32'(ram_ip), 32'hB);
        step();
        wr_valid = 1'b0;
        check_eq("sw_count1", 32'(count), 32'd1);
        check_eq("sw_not_valid_yet", 32'(rd_valid), 32'd0);
        step();
        check_eq("sw_issue_count", 32'(count), 32'd0);
        check_eq("sw_rdwait_ready", 32'(wr_ready), 32'd0);
        check_eq("sw_rdwait_rd_wr", 32'(ram_rd_wr), 32'd1);
        step();
        check_eq("sw_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("sw_rd_data", 32'(rd_data), 32'hB);
        check_eq("sw_count0", 32'(count), 32'd0);
        check_eq("sw_not_empty", 32'(empty), 32'd0);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check_eq("sw_popped", 32'(rd_valid), 32'd0);
        check_eq("sw_empty", 32'(empty), 32'd1);

        // Fill: words 0..F plus one more; word 0 sits in the output register
        for (int i = 0; i < 16; i++) push(4'(i));
        push(4'h5);
        check_eq("fill_count", 32'(count), 32'd16);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("fill_rd_data", 32'(rd_data), 32'h0);
        wr_valid = 1'b1;
        wr_data  = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
            check_eq("full_rd_wr", 32'(ram_rd_wr), 32'd1);
            step();
        end
        wr_valid = 1'b0;
        check_eq("full_count_held", 32'(count), 32'd16);

        // Drain in order; each refill takes RD_LAT+1 cycles after a pop
        for (int i = 0; i < 17; i++) begin
            exp_d = (i == 16) ? 4'h5 : 4'(i);
            pop_expect("drain_data", exp_d, w);
            if (i > 0) check_eq("drain_gap", 32'(w), 32'(RD_LAT + 1));
        end
        check_eq("drain_empty", 32'(empty), 32'd1);
        check_eq("drain_count", 32'(count), 32'd0);

        // Wrap: random valid/ready against a queue scoreboard
        sent = 0;
        got  = 0;
        cyc  = 0;
        nxt  = 4'h3;
        while (got < 40 && cyc < 2000) begin
            wr_valid = (sent < 40) && ($urandom_range(1, 0) == 1);
            wr_data  = nxt;
            rd_ready = ($urandom_range(1, 0) == 1);
            #1;
            acc_w = wr_valid && wr_ready;
            acc_r = rd_valid && rd_ready;
            cap   = rd_data;
            step();
            cyc++;
            if (acc_w) begin
                q.push_back(nxt);
                nxt = nxt + 4'd7;
                sent++;
            end
            if (acc_r) begin
                if (q.size() == 0) check_eq("wrap_underflow", 32'd1, 32'd0);
                else check_eq("wrap_data", 32'(cap), 32'(q.pop_front()));
                got++;
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check_eq("wrap_got", 32'(got), 32'd40);
        step();
        check_eq("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous pop and push
        push(4'hA);
        push(4'hB);
        check_eq("sim_rd_data", 32'(rd_data), 32'hA);
        check_eq("sim_count1", 32'(count), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 4'hC;
        rd_ready = 1'b1;
        #1;
        check_eq("sim_wr_ready", 32'(wr_ready), 32'd1);
        step();
        rd_ready = 1'b0;
        wr_data  = 4'hD;
        check_eq("sim_count2", 32'(count), 32'd2);
        check_eq("sim_rd_valid0", 32'(rd_valid), 32'd0);
        check_eq("sim_block", 32'(wr_ready), 32'd0);
        step();
        check_eq("sim_rdwait_rd_wr", 32'(ram_rd_wr), 32'd1);
        check_eq("sim_rdwait_ready", 32'(wr_ready), 32'd0);
        check_eq("sim_count_issue", 32'(count), 32'd1);
        wr_valid = 1'b0;
        pop_expect("sim_pop_b", 4'hB, w);
        pop_expect("sim_pop_c", 4'hC, w);
        check_eq("sim_empty", 32'(empty), 32'd1);

        // Reset during an in-flight read
        push(4'h6);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rd_wr", 32'(ram_rd_wr), 32'd1);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_valid", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_empty", 32'(empty), 32'd1);
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check_eq("mid_rst_aborted", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_still_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
